// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle CPU control FSM.
// Holds state encodings, instruction decode constants, ALU op codes, datapath
// mux select values and exception vector selects used by cpu_ctrl_fsm.
package cpu_ctrl_pkg;

  // FSM states; the encoding is also exported on the State debug port.
  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_R_EXEC  = 4'd3,
    ST_WB_R    = 4'd4,
    ST_I_EXEC  = 4'd5,
    ST_WB_I    = 4'd6,
    ST_BRANCH  = 4'd7,
    ST_JUMP    = 4'd8,
    ST_EXC_EPC = 4'd9,
    ST_EXC_RD  = 4'd10,
    ST_EXC_PC  = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ula32 operation codes
  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  // Memory address select
  localparam logic [2:0] IORD_PC     = 3'd0;
  localparam logic [2:0] IORD_RES    = 3'd1;
  localparam logic [2:0] IORD_ALUOUT = 3'd2;
  localparam logic [2:0] IORD_EXC    = 3'd3;
  localparam logic [2:0] IORD_A      = 3'd4;
  localparam logic [2:0] IORD_B      = 3'd5;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_A   = 2'd1;
  localparam logic [1:0] SRCA_MDR = 2'd2;

  localparam logic [1:0] SRCB_B        = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_SEXT     = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

  // Register file destination select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;

  // PC source select
  localparam logic [2:0] PCSRC_RES    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_MDR    = 3'd4;
  localparam logic [2:0] PCSRC_EPC    = 3'd5;

  // Exception vector selects: the datapath maps these to vector bytes
  // 253 (invalid opcode) and 254 (overflow).
  localparam int EXC_SEL_INVALID = 0;
  localparam int EXC_SEL_OVF     = 1;

  // States that issue a memory read and therefore hold for MEM_WAIT cycles.
  function automatic logic is_read_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_EXC_RD);
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// ctrl_wait_cnt: 3-bit memory wait down-counter shared by the read states.
// Ports: clk, rst_n (async active-low), load/load_val (restart count),
//        dec (count down while > 0), done (count has reached zero).
module ctrl_wait_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign done = (cnt_q == 3'd0);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle control FSM for the single-bus CPU datapath.
// Inputs: clk, reset (async active-low), OPCODE/FUNCT from IR, Eq/Ofw ALU flags.
// Outputs: every datapath mux select / write enable, Excpt_Sel, State (debug).
// Optional macro CTRL_OVF_TRAP_EN: when defined, ADD/SUB/ADDI overflow traps
// through the overflow vector; when undefined Ofw is ignored.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT  = 2,  // memory read latency, legal 1..7
  parameter int EXC_VEC_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OPCODE,
  input  logic [5:0]           FUNCT,
  input  logic                 Eq,
  input  logic                 Ofw,
  output logic                 PC_Write,
  output logic [2:0]           IorD,
  output logic                 MEM_write_or_read,
  output logic                 IR_Write,
  output logic [1:0]           RegDst,
  output logic                 RegWrite,
  output logic                 AB_Write,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUCtrl,
  output logic                 ALUOutCtrl,
  output logic [2:0]           PCSource,
  output logic [3:0]           DataSrc,
  output logic                 EPC_Write,
  output logic                 MDR_Write,
  output logic [EXC_VEC_W-1:0] Excpt_Sel,
  output logic [3:0]           State
);

  // Counter runs MEM_WAIT-1 .. 0, so the read state's last cycle is done=1.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_t               state_q, state_d;
  logic [EXC_VEC_W-1:0] exc_sel_q, exc_sel_d, exc_new;
  logic                 cnt_load, cnt_done;
  logic                 ovf_trap;

`ifdef CTRL_OVF_TRAP_EN
  assign ovf_trap = Ofw;
`else
  logic unused_ofw;
  assign unused_ofw = Ofw;
  assign ovf_trap   = 1'b0;
`endif

  // Restart the wait count whenever a read state is newly entered.
  assign cnt_load = is_read_state(state_d) && (state_d != state_q);

  ctrl_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (is_read_state(state_q)),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RESET;
      exc_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      exc_sel_q <= exc_sel_d;
    end
  end

  // Next state and Moore outputs (plus the Mealy branch PC_Write).
  always_comb begin
    state_d    = state_q;
    exc_new    = EXC_VEC_W'(EXC_SEL_INVALID);
    PC_Write   = 1'b0;
    IorD       = IORD_PC;
    IR_Write   = 1'b0;
    RegDst     = REGDST_RT;
    RegWrite   = 1'b0;
    AB_Write   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ALUCtrl    = ALU_NOP;
    ALUOutCtrl = 1'b0;
    PCSource   = PCSRC_RES;
    EPC_Write  = 1'b0;
    MDR_Write  = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        IorD    = IORD_PC;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        ALUCtrl = ALU_ADD;
        if (cnt_done) begin
          PC_Write = 1'b1;
          PCSource = PCSRC_RES;
          IR_Write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        AB_Write   = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_SEXT_SH2;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
        case (OPCODE)
          OP_RTYPE:       state_d = ST_R_EXEC;
          OP_ADDI:        state_d = ST_I_EXEC;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_EXC_EPC;
        endcase
      end

      ST_R_EXEC: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUOutCtrl = 1'b1;
        state_d    = ST_WB_R;
        case (FUNCT)
          FN_ADD:  ALUCtrl = ALU_ADD;
          FN_SUB:  ALUCtrl = ALU_SUB;
          FN_AND:  ALUCtrl = ALU_AND;
          default: state_d = ST_EXC_EPC;
        endcase
        if (ovf_trap && ((FUNCT == FN_ADD) || (FUNCT == FN_SUB))) begin
          state_d = ST_EXC_EPC;
          exc_new = EXC_VEC_W'(EXC_SEL_OVF);
        end
      end

      ST_WB_R: begin
        RegDst   = REGDST_RD;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_I_EXEC: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_SEXT;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
        if (ovf_trap) begin
          state_d = ST_EXC_EPC;
          exc_new = EXC_VEC_W'(EXC_SEL_OVF);
        end else begin
          state_d = ST_WB_I;
        end
      end

      ST_WB_I: begin
        RegDst   = REGDST_RT;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_BRANCH: begin
        // ALUOut keeps the target computed in decode; IR still holds OPCODE.
        ALUSrcA  = SRCA_A;
        ALUSrcB  = SRCB_B;
        ALUCtrl  = ALU_CMP;
        PCSource = PCSRC_ALUOUT;
        PC_Write = (OPCODE == OP_BNE) ? !Eq : Eq;
        state_d  = ST_FETCH;
      end

      ST_JUMP: begin
        PC_Write = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = ST_FETCH;
      end

      ST_EXC_EPC: begin
        // PC was already advanced by fetch; EPC gets PC-4.
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUCtrl   = ALU_SUB;
        EPC_Write = 1'b1;
        state_d   = ST_EXC_RD;
      end

      ST_EXC_RD: begin
        IorD = IORD_EXC;
        if (cnt_done) begin
          MDR_Write = 1'b1;
          state_d   = ST_EXC_PC;
        end
      end

      ST_EXC_PC: begin
        PC_Write = 1'b1;
        PCSource = PCSRC_MDR;
        state_d  = ST_FETCH;
      end

      default: state_d = ST_RESET;
    endcase
  end

  // Exception select: captured on entry to EXC_EPC, held through EXC_PC.
  always_comb begin
    exc_sel_d = '0;
    case (state_d)
      ST_EXC_EPC:           exc_sel_d = (state_q == ST_EXC_EPC) ? exc_sel_q : exc_new;
      ST_EXC_RD, ST_EXC_PC: exc_sel_d = exc_sel_q;
      default:              exc_sel_d = '0;
    endcase
  end

  assign MEM_write_or_read = 1'b0;
  assign DataSrc           = 4'd0;
  assign Excpt_Sel         = exc_sel_q;
  assign State             = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: self-checking bench for cpu_ctrl_fsm.
// Builds the expected per-cycle control word of each instruction from the
// instruction-level rules and compares it every cycle against the DUT.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  localparam int MW = 2;
`ifdef CTRL_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OPCODE, FUNCT;
  logic       Eq, Ofw;
  logic       PC_Write, MEM_write_or_read, IR_Write, RegWrite, AB_Write;
  logic       ALUOutCtrl, EPC_Write, MDR_Write;
  logic [2:0] IorD, ALUCtrl, PCSource;
  logic [1:0] RegDst, ALUSrcA, ALUSrcB;
  logic [3:0] DataSrc, State;
  logic [0:0] Excpt_Sel;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.MEM_WAIT(MW), .EXC_VEC_W(1)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Eq(Eq), .Ofw(Ofw),
    .PC_Write(PC_Write), .IorD(IorD), .MEM_write_or_read(MEM_write_or_read),
    .IR_Write(IR_Write), .RegDst(RegDst), .RegWrite(RegWrite), .AB_Write(AB_Write),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .ALUOutCtrl(ALUOutCtrl),
    .PCSource(PCSource), .DataSrc(DataSrc), .EPC_Write(EPC_Write),
    .MDR_Write(MDR_Write), .Excpt_Sel(Excpt_Sel), .State(State)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [2:0] iord;
    logic       memw;
    logic       irw;
    logic [1:0] regdst;
    logic       regw;
    logic       abw;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       aluout;
    logic [2:0] pcsrc;
    logic [3:0] datasrc;
    logic       epcw;
    logic       mdrw;
    logic       exc;
  } ctl_t;

  ctl_t obs;
  assign obs = {State, PC_Write, IorD, MEM_write_or_read, IR_Write, RegDst, RegWrite,
                AB_Write, ALUSrcA, ALUSrcB, ALUCtrl, ALUOutCtrl, PCSource, DataSrc,
                EPC_Write, MDR_Write, Excpt_Sel};

  int   n_chk  = 0;
  int   n_pass = 0;
  ctl_t exp_q[$];

  function automatic ctl_t blank(input state_t s);
    ctl_t r = '0;
    r.st = s;
    return r;
  endfunction

  task automatic check(input string tag, input ctl_t o, input ctl_t e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Expected control words of one instruction, cycle by cycle. eq/ofw are the
  // flag values present in the execute cycle (the only cycle that uses them).
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic eq, input logic ofw);
    ctl_t r;
    bit   take_exc = 0;
    bit   sel = 0;
    exp_q.delete();
    for (int k = 0; k < MW; k++) begin
      r = blank(ST_FETCH); r.srcb = 2'd1; r.alu = 3'b001;
      if (k == MW - 1) begin r.pcw = 1'b1; r.irw = 1'b1; end
      exp_q.push_back(r);
    end
    r = blank(ST_DECODE); r.abw = 1'b1; r.srcb = 2'd3; r.alu = 3'b001; r.aluout = 1'b1;
    exp_q.push_back(r);
    if (op == 6'h00) begin
      r = blank(ST_R_EXEC); r.srca = 2'd1; r.aluout = 1'b1;
      if (fn == 6'h20) r.alu = 3'b001;
      else if (fn == 6'h22) r.alu = 3'b010;
      else if (fn == 6'h24) r.alu = 3'b011;
      else take_exc = 1;
      if (OVF_EN && ofw && (fn == 6'h20 || fn == 6'h22)) begin take_exc = 1; sel = 1; end
      exp_q.push_back(r);
      if (!take_exc) begin
        r = blank(ST_WB_R); r.regdst = 2'd1; r.regw = 1'b1; exp_q.push_back(r);
      end
    end else if (op == 6'h08) begin
      r = blank(ST_I_EXEC); r.srca = 2'd1; r.srcb = 2'd2; r.alu = 3'b001; r.aluout = 1'b1;
      exp_q.push_back(r);
      if (OVF_EN && ofw) begin take_exc = 1; sel = 1; end
      else begin r = blank(ST_WB_I); r.regw = 1'b1; exp_q.push_back(r); end
    end else if (op == 6'h04 || op == 6'h05) begin
      r = blank(ST_BRANCH); r.srca = 2'd1; r.alu = 3'b111; r.pcsrc = 3'd1;
      r.pcw = (op == 6'h04) ? eq : !eq;
      exp_q.push_back(r);
    end else if (op == 6'h02) begin
      r = blank(ST_JUMP); r.pcw = 1'b1; r.pcsrc = 3'd2; exp_q.push_back(r);
    end else begin
      take_exc = 1;
    end
    if (take_exc) begin
      r = blank(ST_EXC_EPC); r.srcb = 2'd1; r.alu = 3'b010; r.epcw = 1'b1; r.exc = sel;
      exp_q.push_back(r);
      for (int k = 0; k < MW; k++) begin
        r = blank(ST_EXC_RD); r.iord = 3'd3; r.exc = sel; r.mdrw = (k == MW - 1);
        exp_q.push_back(r);
      end
      r = blank(ST_EXC_PC); r.pcw = 1'b1; r.pcsrc = 3'd4; r.exc = sel;
      exp_q.push_back(r);
    end
  endtask

  // Entered 1 time unit after a rising edge, in cycle 0 of the instruction.
  // eq_f/ofw_f < 0 leave the execute-cycle flag random; abort_at >= 0 pulls
  // reset low in that cycle of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int eq_f, input int ofw_f, input int abort_at);
    logic eq_v[32];
    logic ofw_v[32];
    for (int i = 0; i < 32; i++) begin
      eq_v[i]  = 1'($urandom);
      ofw_v[i] = 1'($urandom);
    end
    if (eq_f >= 0)  eq_v[MW + 1]  = eq_f[0];
    if (ofw_f >= 0) ofw_v[MW + 1] = ofw_f[0];
    build(op, fn, eq_v[MW + 1], ofw_v[MW + 1]);
    for (int i = 0; i < exp_q.size(); i++) begin
      OPCODE = (i < MW) ? 6'($urandom) : op;
      FUNCT  = (i < MW) ? 6'($urandom) : fn;
      Eq     = eq_v[i];
      Ofw    = ofw_v[i];
      if (i == abort_at) begin
        #3 reset = 1'b0;
        #1 check("rst_async", obs, blank(ST_RESET));
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", obs, blank(ST_RESET));
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      check($sformatf("op%02h_fn%02h_c%0d", op, fn, i), obs, exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] rop, rfn;

  initial begin
    reset  = 1'b1;
    OPCODE = '0; FUNCT = '0; Eq = 1'b0; Ofw = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset", obs, blank(ST_RESET));
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed instructions
    run_instr(6'h00, 6'h20, -1, 0, -1);   // ADD, no overflow
    run_instr(6'h00, 6'h22, -1, 0, -1);   // SUB
    run_instr(6'h00, 6'h24, -1, 1, -1);   // AND ignores Ofw
    run_instr(6'h08, 6'h00, -1, 1, -1);   // ADDI with overflow
    run_instr(6'h08, 6'h11, -1, 0, -1);   // ADDI no overflow
    run_instr(6'h00, 6'h20, -1, 1, -1);   // ADD with overflow
    run_instr(6'h04, 6'h00, 1, -1, -1);   // BEQ taken
    run_instr(6'h04, 6'h00, 0, -1, -1);   // BEQ not taken
    run_instr(6'h05, 6'h00, 1, -1, -1);   // BNE not taken
    run_instr(6'h05, 6'h00, 0, -1, -1);   // BNE taken
    run_instr(6'h3F, 6'h00, -1, -1, -1);  // invalid opcode
    run_instr(6'h00, 6'h3F, -1, -1, -1);  // invalid funct
    run_instr(6'h02, 6'h00, -1, -1, -1);  // J
    run_instr(6'h00, 6'h20, -1, 0, MW + 1); // reset during R_EXEC
    run_instr(6'h00, 6'h22, -1, 0, -1);   // clean restart after reset

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      rfn = 6'($urandom);
      case ($urandom_range(0, 6))
        0: begin
          rop = 6'h00;
          case ($urandom_range(0, 3))
            0: rfn = 6'h20;
            1: rfn = 6'h22;
            2: rfn = 6'h24;
            default: ;
          endcase
        end
        1: rop = 6'h08;
        2: rop = 6'h04;
        3: rop = 6'h05;
        4: rop = 6'h02;
        5: begin
          rop = 6'($urandom);
          while (rop == 6'h00 || rop == 6'h02 || rop == 6'h04 || rop == 6'h05 || rop == 6'h08)
            rop = 6'($urandom);
        end
        default: begin rop = 6'h00; rfn = 6'h20; end
      endcase
      run_instr(rop, rfn, -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
